// File: rtl/apa102_pkg.sv
// ============================================================================
// apa102_pkg : shared constants and state encoding for the APA102 receiver
// Rev 1.0
// ============================================================================
`default_nettype none

package apa102_pkg;

    localparam int         WORD_BITS  = 32;
    localparam logic [2:0] HDR        = 3'b111;

    localparam int         HDR_MSB    = 31;
    localparam int         BRIGHT_MSB = 28;
    localparam int         BLUE_MSB   = 23;
    localparam int         GREEN_MSB  = 15;
    localparam int         RED_MSB    = 7;

    // Zero-run counter must be able to hold WORD_BITS itself (saturating value)
    localparam int         RUN_W      = $clog2(WORD_BITS + 1);

    typedef logic [1:0] state_t;
    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] PIXEL = 2'd1;
    localparam logic [1:0] TRAIL = 2'd2;

endpackage

`default_nettype wire

// File: rtl/apa102_sampler.sv
// ============================================================================
// apa102_sampler : strip-line synchronisers, falling-edge strobe, word shifter
// Rev 1.0
// ============================================================================
`default_nettype none

module apa102_sampler
    import apa102_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 led_clk,
    input  logic                 led_data,
    input  logic                 align,
    input  logic                 clear_run,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_valid,
    output logic [RUN_W-1:0]     zero_run,
    output logic                 timeout
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [2:0]       clk_sync;
    logic [1:0]       data_sync;
    logic [4:0]       bit_cnt;
    logic [TMR_W-1:0] idle_cnt;
    logic             strobe;
    logic             bit_in;

    // clk_sync[2] is the previous synchronised level, used only for edge detection
    assign strobe = clk_sync[2] & ~clk_sync[1];
    assign bit_in = data_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync   <= '0;
            data_sync  <= '0;
            word       <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            word_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[1:0], led_clk};
            data_sync  <= {data_sync[0], led_data};
            word_valid <= 1'b0;
            timeout    <= 1'b0;
            if (align) begin
                word     <= '0;
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else if (strobe) begin
                word       <= {word[WORD_BITS-2:0], bit_in};
                bit_cnt    <= bit_cnt + 5'd1;
                word_valid <= (bit_cnt == 5'(WORD_BITS - 1));
                idle_cnt   <= '0;
            end else if (bit_cnt != 5'd0) begin
                if (idle_cnt == TMR_W'(TIMEOUT - 1)) begin
                    timeout  <= 1'b1;
                    word     <= '0;
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TMR_W'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_run <= '0;
        end else if (clear_run) begin
            zero_run <= '0;
        end else if (strobe) begin
            if (bit_in)
                zero_run <= '0;
            else if (zero_run != RUN_W'(WORD_BITS))
                zero_run <= zero_run + RUN_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/apa102_rx.sv
// ============================================================================
// apa102_rx : APA102 strip receiver - framing FSM and decoded pixel outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module apa102_rx
    import apa102_pkg::*;
#(
    parameter int NUM_LEDS = 64,
    parameter int IDX_W    = 6,
    parameter int TIMEOUT  = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             led_clk,
    input  logic             led_data,
    output logic             pix_valid,
    output logic [IDX_W-1:0] pix_index,
    output logic [4:0]       pix_bright,
    output logic [7:0]       pix_blue,
    output logic [7:0]       pix_green,
    output logic [7:0]       pix_red,
    output logic             frame_start,
    output logic             frame_done,
    output logic             frame_err
);

    logic [WORD_BITS-1:0] word;
    logic                 word_valid;
    logic [RUN_W-1:0]     zero_run;
    logic                 timeout;
    logic                 align;
    logic                 clear_run;

    state_t               state, state_nx;
    logic [IDX_W-1:0]     idx, idx_nx;
    logic                 valid_nx, start_nx, done_nx, err_nx;

    apa102_sampler #(
        .TIMEOUT (TIMEOUT)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .led_clk    (led_clk),
        .led_data   (led_data),
        .align      (align),
        .clear_run  (clear_run),
        .word       (word),
        .word_valid (word_valid),
        .zero_run   (zero_run),
        .timeout    (timeout)
    );

    // Every entry to HUNT or TRAIL restarts the zero run so stale trailing
    // zeros of a data word can never complete a start/end frame early.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        err_nx    = frame_err;
        valid_nx  = 1'b0;
        start_nx  = 1'b0;
        done_nx   = 1'b0;
        align     = 1'b0;
        clear_run = 1'b0;
        if (timeout) begin
            if (state == PIXEL)
                err_nx = 1'b1;
            state_nx  = HUNT;
            clear_run = 1'b1;
        end else begin
            case (state)
                HUNT, TRAIL: begin
                    if (zero_run == RUN_W'(WORD_BITS)) begin
                        clear_run = 1'b1;
                        if (state == HUNT) begin
                            start_nx = 1'b1;
                            idx_nx   = '0;
                            err_nx   = 1'b0;
                            align    = 1'b1;
                            state_nx = PIXEL;
                        end else begin
                            state_nx = HUNT;
                        end
                    end
                end
                PIXEL: begin
                    if (word_valid) begin
                        if (word[HDR_MSB -: 3] == HDR) begin
                            valid_nx = 1'b1;
                            if (idx == IDX_W'(NUM_LEDS - 1)) begin
                                done_nx   = 1'b1;
                                state_nx  = TRAIL;
                                clear_run = 1'b1;
                            end else begin
                                idx_nx = idx + IDX_W'(1);
                            end
                        end else if (word == '0) begin
                            start_nx = 1'b1;
                            idx_nx   = '0;
                            err_nx   = 1'b0;
                        end else begin
                            err_nx    = 1'b1;
                            state_nx  = HUNT;
                            clear_run = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx  = HUNT;
                    clear_run = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HUNT;
            idx         <= '0;
            pix_valid   <= 1'b0;
            pix_index   <= '0;
            pix_bright  <= '0;
            pix_blue    <= '0;
            pix_green   <= '0;
            pix_red     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            pix_valid   <= valid_nx;
            frame_start <= start_nx;
            frame_done  <= done_nx;
            frame_err   <= err_nx;
            if (valid_nx) begin
                pix_index  <= idx;
                pix_bright <= word[BRIGHT_MSB -: 5];
                pix_blue   <= word[BLUE_MSB -: 8];
                pix_green  <= word[GREEN_MSB -: 8];
                pix_red    <= word[RED_MSB -: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apa102_rx.sv
// ============================================================================
// tb_apa102_rx : directed bench for apa102_rx (64-LED and 2-LED instances)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_apa102_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic lc    = 1'b0;
    logic ld    = 1'b0;

    logic       b_valid, b_start, b_done, b_err;
    logic [5:0] b_idx;
    logic [4:0] b_br;
    logic [7:0] b_bl, b_gr, b_rd;

    logic       a_valid, a_start, a_done, a_err;
    logic [0:0] a_idx;
    logic [4:0] a_br;
    logic [7:0] a_bl, a_gr, a_rd;

    apa102_rx dut64 (
        .clk (clk), .reset (rst_n), .led_clk (lc), .led_data (ld),
        .pix_valid (b_valid), .pix_index (b_idx), .pix_bright (b_br),
        .pix_blue (b_bl), .pix_green (b_gr), .pix_red (b_rd),
        .frame_start (b_start), .frame_done (b_done), .frame_err (b_err)
    );

    apa102_rx #(.NUM_LEDS(2), .IDX_W(1), .TIMEOUT(4096)) dut2 (
        .clk (clk), .reset (rst_n), .led_clk (lc), .led_data (ld),
        .pix_valid (a_valid), .pix_index (a_idx), .pix_bright (a_br),
        .pix_blue (a_bl), .pix_green (a_gr), .pix_red (a_rd),
        .frame_start (a_start), .frame_done (a_done), .frame_err (a_err)
    );

    typedef struct {
        int idx; int br; int bl; int gr; int rd; int done;
    } pix_t;

    typedef struct {
        logic [31:0] word; int ph;
        int idx; int br; int bl; int gr; int rd;
    } vec_t;

    pix_t qa[$];
    pix_t qb[$];
    int   starts_a = 0, dones_a = 0, ovl_a = 0;
    int   starts_b = 0, dones_b = 0, ovl_b = 0;
    int   nchecks = 0, nerr = 0;

    always @(negedge clk) begin
        if (b_valid) qb.push_back('{idx: int'(b_idx), br: int'(b_br), bl: int'(b_bl),
                                    gr: int'(b_gr), rd: int'(b_rd), done: int'(b_done)});
        if (b_start) starts_b++;
        if (b_done) dones_b++;
        if (b_start && b_valid) ovl_b++;
    end

    always @(negedge clk) begin
        if (a_valid) qa.push_back('{idx: int'(a_idx), br: int'(a_br), bl: int'(a_bl),
                                    gr: int'(a_gr), rd: int'(a_rd), done: int'(a_done)});
        if (a_start) starts_a++;
        if (a_done) dones_a++;
        if (a_start && a_valid) ovl_a++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int ph);
        ld = b;
        lc = 1'b1;
        repeat (ph) @(negedge clk);
        lc = 1'b0;
        repeat (ph) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int ph);
        for (int i = 31; i >= 0; i--) send_bit(w[i], ph);
    endtask

    task automatic flush();
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        lc    = 1'b0;
        ld    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_b(input string tag, input int pos, input int idx, input int br,
                           input int bl, input int gr, input int rd);
        if (qb.size() <= pos) begin
            check({tag, "_present"}, qb.size(), pos + 1);
        end else begin
            check({tag, "_idx"},    qb[pos].idx, idx);
            check({tag, "_bright"}, qb[pos].br,  br);
            check({tag, "_blue"},   qb[pos].bl,  bl);
            check({tag, "_green"},  qb[pos].gr,  gr);
            check({tag, "_red"},    qb[pos].rd,  rd);
        end
    endtask

    initial begin
        vec_t        vt[6];
        int          base, sbase, dbase;
        logic [31:0] w;

        vt[0] = '{32'hE1020304, 1, 0, 'h01, 'h02, 'h03, 'h04};
        vt[1] = '{32'hFFFFFFFF, 2, 1, 'h1F, 'hFF, 'hFF, 'hFF};
        vt[2] = '{32'hE0000000, 1, 2, 'h00, 'h00, 'h00, 'h00};
        vt[3] = '{32'hEAA55AA5, 3, 3, 'h0A, 'hA5, 'h5A, 'hA5};
        vt[4] = '{32'hF5123456, 1, 4, 'h15, 'h12, 'h34, 'h56};
        vt[5] = '{32'hE7808182, 2, 5, 'h07, 'h80, 'h81, 'h82};

        // Reset state of both instances
        repeat (3) @(negedge clk);
        check("reset_outputs_64", {b_valid, b_idx, b_br, b_bl, b_gr, b_rd, b_start, b_done, b_err}, 0);
        check("reset_outputs_2",  {a_valid, a_idx, a_br, a_bl, a_gr, a_rd, a_start, a_done, a_err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-pixel frame on the NUM_LEDS=2 instance
        base = qa.size(); sbase = starts_a; dbase = dones_a;
        send_word(32'h0, 2);
        send_word(32'hF0000F00, 2);
        send_word(32'hF0070000, 2);
        send_word(32'h0, 2);
        flush();
        check("two_starts", starts_a - sbase, 1);
        check("two_count", qa.size() - base, 2);
        if (qa.size() >= base + 2) begin
            check("two_p0", {qa[base].idx, qa[base].br, qa[base].bl, qa[base].gr, qa[base].rd, qa[base].done},
                  {32'd0, 32'h10, 32'h00, 32'h0F, 32'h00, 32'd0});
            check("two_p1", {qa[base+1].idx, qa[base+1].br, qa[base+1].bl, qa[base+1].gr, qa[base+1].rd, qa[base+1].done},
                  {32'd1, 32'h10, 32'h07, 32'h00, 32'h00, 32'd1});
        end
        check("two_dones", dones_a - dbase, 1);
        check("two_err", a_err, 0);

        // Table of pixel words with varied strip-clock phases
        do_reset();
        base = qb.size();
        send_word(32'h0, 1);
        flush();
        for (int i = 0; i < 6; i++) begin
            send_word(vt[i].word, vt[i].ph);
            flush();
            check($sformatf("vec%0d_count", i), qb.size() - base, i + 1);
            check_b($sformatf("vec%0d", i), base + i, vt[i].idx, vt[i].br, vt[i].bl, vt[i].gr, vt[i].rd);
        end
        check("vec_err", b_err, 0);

        // Full 64-pixel frame, red = index, 1-clk phases
        do_reset();
        base = qb.size(); dbase = dones_b;
        send_word(32'h0, 1);
        for (int i = 0; i < 64; i++) begin
            w = {8'hFF, 16'h0000, 8'(i)};
            send_word(w, 1);
        end
        send_word(32'h0, 1);
        flush();
        check("full_count", qb.size() - base, 64);
        if (qb.size() >= base + 64) begin
            for (int i = 0; i < 64; i++) begin
                check($sformatf("full%0d_idx", i), qb[base+i].idx, i);
                check($sformatf("full%0d_red", i), qb[base+i].rd, i);
            end
            check("full_done_last", qb[base+63].done, 1);
            check("full_done_early", qb[base+62].done, 0);
        end
        check("full_dones", dones_b - dbase, 1);
        check("full_err", b_err, 0);

        // Bad header
        do_reset();
        base = qb.size(); sbase = starts_b;
        send_word(32'h0, 2);
        send_word(32'h70000000, 2);
        flush();
        check("bad_err_set", b_err, 1);
        check("bad_no_valid", qb.size() - base, 0);
        send_word(32'hFF0000FF, 2);
        flush();
        check("bad_hunt_ignores", qb.size() - base, 0);
        send_word(32'h0, 2);
        flush();
        check("bad_err_cleared", b_err, 0);
        check("bad_restart", starts_b - sbase, 2);
        send_word(32'hE1000005, 2);
        flush();
        check_b("bad_after", base, 0, 'h01, 'h00, 'h00, 'h05);

        // Timeout on a partial word
        do_reset();
        base = qb.size();
        send_word(32'h0, 1);
        for (int i = 0; i < 12; i++) send_bit((i < 4) ? 1'b1 : 1'b0, 1);
        repeat (4096 - 16) @(negedge clk);
        check("tmo_not_early", b_err, 0);
        repeat (24) @(negedge clk);
        check("tmo_err", b_err, 1);
        check("tmo_no_valid", qb.size() - base, 0);
        send_word(32'h0, 1);
        send_word(32'hF1020304, 1);
        flush();
        check("tmo_err_cleared", b_err, 0);
        check_b("tmo_after", base, 0, 'h11, 'h02, 'h03, 'h04);

        // Mid-frame restart
        do_reset();
        base = qb.size(); sbase = starts_b;
        send_word(32'h0, 3);
        send_word(32'hE1000001, 3);
        send_word(32'hE1000002, 3);
        send_word(32'hE1000003, 3);
        send_word(32'h0, 3);
        flush();
        check("mid_starts", starts_b - sbase, 2);
        check("mid_count", qb.size() - base, 3);
        send_word(32'hE1000009, 3);
        flush();
        check_b("mid_after", base + 3, 0, 'h01, 'h00, 'h00, 'h09);

        // Asynchronous reset midway through bit 17
        do_reset();
        send_word(32'h0, 1);
        send_word(32'hF5123456, 1);
        send_word(32'hE1000001, 1);
        flush();
        check("pre_reset_fields", {b_idx, b_rd}, {6'd1, 8'h01});
        w = 32'hF0000F00;
        for (int i = 31; i >= 18; i--) send_bit(w[i], 1);
        ld = w[17];
        lc = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {b_valid, b_idx, b_br, b_bl, b_gr, b_rd, b_start, b_done, b_err}, 0);
        lc = 1'b0;
        ld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = qb.size(); sbase = starts_b;
        flush();
        check("post_reset_quiet", qb.size() - base, 0);
        send_word(32'h0, 1);
        flush();
        check("post_reset_start", starts_b - sbase, 1);
        check("post_reset_no_valid", qb.size() - base, 0);
        send_word(32'hE1000001, 1);
        flush();
        check_b("post_reset_pix", base, 0, 'h01, 'h00, 'h00, 'h01);

        check("start_valid_overlap", ovl_a + ovl_b, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
